// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode map, immediate formats, decoded-record layout.
// No logic; pure types and constants.
// No flow control.
package rv32i_pkg;

    localparam int WORD_W = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [WORD_W-1:0] imm;
        logic [WORD_W-1:0] pc;
        logic              illegal;
    } decode_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate builder: reassembles and sign-extends the immediate for a given format.
// Combinational, zero latency.
// No flow control.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7]       instr,
    input  imm_fmt_t          fmt,
    output logic [WORD_W-1:0] imm
);

    // Opcode bits are not needed here, so only instr[31:7] is passed in.
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decoder.sv
// RV32I decode stage: field slicing, immediate generation, illegal-opcode flag.
// One-cycle latency; every output registered.
// No backpressure: a new instruction is accepted on every clock edge.
module rv32i_decoder
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr_input,
    input  logic [XLEN-1:0] pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    imm_fmt_t          fmt;
    logic              illegal_d;
    logic [WORD_W-1:0] imm_d;
    decode_t           dec_d;
    decode_t           dec_q;

    // R-type and FENCE are legal but carry no immediate.
    always_comb begin
        fmt       = IMM_NONE;
        illegal_d = 1'b0;
        case (instr_input[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = IMM_I;
            OP_STORE:                            fmt = IMM_S;
            OP_BRANCH:                           fmt = IMM_B;
            OP_LUI, OP_AUIPC:                    fmt = IMM_U;
            OP_JAL:                              fmt = IMM_J;
            OP_REG, OP_FENCE:                    fmt = IMM_NONE;
            default:                             illegal_d = 1'b1;
        endcase
    end

    rv32i_imm_gen u_imm_gen (
        .instr (instr_input[31:7]),
        .fmt   (fmt),
        .imm   (imm_d)
    );

    always_comb begin
        dec_d         = '0;
        dec_d.opcode  = instr_input[6:0];
        dec_d.rs1     = instr_input[19:15];
        dec_d.rs2     = instr_input[24:20];
        dec_d.rd      = instr_input[11:7];
        dec_d.funct3  = instr_input[14:12];
        dec_d.funct7  = instr_input[31:25];
        dec_d.imm     = imm_d;
        dec_d.pc      = pc;
        dec_d.illegal = illegal_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign opcode  = dec_q.opcode;
    assign rs1     = dec_q.rs1;
    assign rs2     = dec_q.rs2;
    assign rd      = dec_q.rd;
    assign funct3  = dec_q.funct3;
    assign funct7  = dec_q.funct7;
    assign imm     = dec_q.imm;
    assign pc_out  = dec_q.pc;
    assign illegal = dec_q.illegal;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Scoreboard bench for rv32i_decoder: directed instruction words with hand-decoded fields.
module tb_rv32i_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_input;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic        illegal;

    always #5 clk = ~clk;

    rv32i_decoder #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_input (instr_input),
        .pc          (pc),
        .opcode      (opcode),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .funct3      (funct3),
        .funct7      (funct7),
        .imm         (imm),
        .pc_out      (pc_out),
        .illegal     (illegal)
    );

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } rec_t;

    rec_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic rec_t sample();
        rec_t r;
        r.opcode  = opcode;
        r.rs1     = rs1;
        r.rs2     = rs2;
        r.rd      = rd;
        r.funct3  = funct3;
        r.funct7  = funct7;
        r.imm     = imm;
        r.pc      = pc_out;
        r.illegal = illegal;
        return r;
    endfunction

    task automatic check(input string name, input rec_t act, input rec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got op=%b rs1=%0d rs2=%0d rd=%0d f3=%0d f7=%b imm=%h pc=%h ill=%b, want op=%b rs1=%0d rs2=%0d rd=%0d f3=%0d f7=%b imm=%h pc=%h ill=%b",
                     name, act.opcode, act.rs1, act.rs2, act.rd, act.funct3, act.funct7, act.imm, act.pc, act.illegal,
                     exp.opcode, exp.rs1, exp.rs2, exp.rd, exp.funct3, exp.funct7, exp.imm, exp.pc, exp.illegal);
        end
    endtask

    // Monitor: every registered edge outside reset retires one expectation.
    always @(posedge clk) begin : monitor
        rec_t  e;
        string n;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, sample(), e);
        end
    end

    // Drives one word now and queues what the next edge must produce.
    task automatic issue(input string name, input logic [31:0] w, input logic [31:0] a,
                         input logic [6:0] op, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                         input logic [4:0] e_rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] e_imm, input logic ill);
        rec_t e;
        instr_input = w;
        pc          = a;
        e.opcode  = op;
        e.rd      = e_rd;
        e.rs1     = e_rs1;
        e.rs2     = e_rs2;
        e.funct3  = f3;
        e.funct7  = f7;
        e.imm     = e_imm;
        e.pc      = a;
        e.illegal = ill;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_input = 32'h00500093;
        pc          = 32'h0000_0100;

        #1;
        check("reset_initial", sample(), '0);
        @(posedge clk); #1;
        check("reset_holds_over_edge", sample(), '0);

        @(negedge clk);
        rst_n = 1'b1;
        //     name          word          pc            opcode      rd  rs1 rs2 f3  f7          imm           ill
        issue("addi",      32'h00500093, 32'h0000_1000, 7'b0010011, 1,  0,  5,  0, 7'h00, 32'h0000_0005, 1'b0);
        @(negedge clk);
        issue("add",       32'h002081B3, 32'h0000_1004, 7'b0110011, 3,  1,  2,  0, 7'h00, 32'h0000_0000, 1'b0);
        @(negedge clk);
        issue("sw",        32'h0020A023, 32'h0000_1008, 7'b0100011, 0,  1,  2,  2, 7'h00, 32'h0000_0000, 1'b0);
        @(negedge clk);
        issue("beq",       32'h00208463, 32'h0000_100C, 7'b1100011, 8,  1,  2,  0, 7'h00, 32'h0000_0008, 1'b0);
        @(negedge clk);
        issue("lui",       32'h12345037, 32'h0000_1010, 7'b0110111, 0,  8,  3,  5, 7'h09, 32'h1234_5000, 1'b0);
        @(negedge clk);
        issue("jal",       32'h020000EF, 32'h0000_1014, 7'b1101111, 1,  0,  0,  0, 7'h01, 32'h0000_0020, 1'b0);
        @(negedge clk);
        issue("addi_neg1", 32'hFFF00093, 32'h0000_1018, 7'b0010011, 1,  0,  31, 0, 7'h7F, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        issue("zero_word", 32'h00000000, 32'h0000_101C, 7'b0000000, 0,  0,  0,  0, 7'h00, 32'h0000_0000, 1'b1);
        @(negedge clk);
        issue("sw_neg4",   32'hFE20AE23, 32'h0000_1020, 7'b0100011, 28, 1,  2,  2, 7'h7F, 32'hFFFF_FFFC, 1'b0);
        @(negedge clk);
        issue("beq_neg4",  32'hFE000EE3, 32'h0000_1024, 7'b1100011, 29, 0,  0,  0, 7'h7F, 32'hFFFF_FFFC, 1'b0);
        @(negedge clk);
        issue("auipc",     32'hFFFFF517, 32'h0000_1028, 7'b0010111, 10, 31, 31, 7, 7'h7F, 32'hFFFF_F000, 1'b0);
        @(negedge clk);
        issue("lw_neg4",   32'hFFC12083, 32'h0000_102C, 7'b0000011, 1,  2,  28, 2, 7'h7F, 32'hFFFF_FFFC, 1'b0);
        @(negedge clk);
        issue("jalr",      32'h000080E7, 32'h0000_1030, 7'b1100111, 1,  1,  0,  0, 7'h00, 32'h0000_0000, 1'b0);
        @(negedge clk);
        issue("fence",     32'h0FF0000F, 32'h0000_1034, 7'b0001111, 0,  0,  31, 0, 7'h07, 32'h0000_0000, 1'b0);
        @(negedge clk);
        issue("ecall",     32'h00000073, 32'h0000_1038, 7'b1110011, 0,  0,  0,  0, 7'h00, 32'h0000_0000, 1'b0);
        @(negedge clk);
        issue("unknown",   32'h0000007F, 32'h0000_103C, 7'b1111111, 0,  0,  0,  0, 7'h00, 32'h0000_0000, 1'b1);
        @(negedge clk);
        issue("pre_reset", 32'hFFF00093, 32'hDEAD_BEE0, 7'b0010011, 1,  0,  31, 0, 7'h7F, 32'hFFFF_FFFF, 1'b0);

        // Mid-cycle reset must clear outputs without an edge.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_mid_cycle", sample(), '0);
        @(posedge clk); #1;
        check("reset_mid_holds", sample(), '0);

        // First edge after release captures whatever is on the input.
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_reset_beq", 32'h00208463, 32'h0000_2000, 7'b1100011, 8, 1, 2, 0, 7'h00, 32'h0000_0008, 1'b0);
        @(negedge clk);
        issue("post_reset_jal", 32'h020000EF, 32'h0000_2004, 7'b1101111, 1, 0, 0, 0, 7'h01, 32'h0000_0020, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
